// File: rtl/clock_mode_ctrl.sv
// Mode/setup controller for the HH:MM:SS clock: debounces the three buttons, runs the
// CLOCK/SETUP state machine and drives counter increment enables plus the display blink mask.
module clock_mode_ctrl #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DEB_CYC   = 500_000,
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sec_wrap,
    input  logic       i_min_wrap,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_hour_inc,
    output logic [2:0] o_blink_mask
);
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_TC  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [DW-1:0] DEB_TC  = DW'(DEB_CYC - 1);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);
    localparam logic [BW-1:0] BL_TC   = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BL_ONE  = BW'(1);

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    typedef enum logic {
        ST_CLOCK = 1'b0,
        ST_SETUP = 1'b1
    } state_t;

    function automatic logic [2:0] pos_onehot(input logic [1:0] pos);
        logic [2:0] oh;
        case (pos)
            POS_SEC:  oh = 3'b001;
            POS_MIN:  oh = 3'b010;
            POS_HOUR: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Button path: bit 0 = mode, bit 1 = position, bit 2 = increment (all active-low)
    logic [2:0]    raw_s;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d;
    logic [2:0]    press_q, press_d;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];

    assign raw_s = {i_sw2, i_sw1, i_sw0};

    // Debounce next state: a level is accepted after DEB_CYC consecutive differing cycles
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            deb_d[b]     = deb_q[b];
            press_d[b]   = 1'b0;
            deb_cnt_d[b] = {DW{1'b0}};
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_TC) begin
                    deb_d[b]   = sync2_q[b];
                    press_d[b] = ~sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_ONE;
                end
            end else begin
                deb_cnt_d[b] = {DW{1'b0}};
            end
        end
    end

    // Synchroniser, debounce and press-event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            deb_q   <= 3'b111;
            press_q <= 3'b000;
            for (int b = 0; b < 3; b++) begin
                deb_cnt_q[b] <= {DW{1'b0}};
            end
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int b = 0; b < 3; b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
            end
        end
    end

    state_t        state_q, state_d;
    logic [1:0]    pos_q, pos_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [2:0]    mask_q, mask_d;

    // FSM next state, prescaler, blink phase and increment enables
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        sec_d       = 1'b0;
        min_d       = 1'b0;
        hour_d      = 1'b0;
        case (state_q)
            ST_CLOCK: begin
                min_d       = i_sec_wrap;
                hour_d      = i_min_wrap;
                blink_cnt_d = {BW{1'b0}};
                phase_d     = 1'b0;
                if (presc_q == PRE_TC) begin
                    presc_d = {PW{1'b0}};
                    sec_d   = 1'b1;
                end else begin
                    presc_d = presc_q + PRE_ONE;
                end
                if (press_q[0]) begin
                    state_d = ST_SETUP;
                    pos_d   = POS_SEC;
                    presc_d = {PW{1'b0}};
                end else begin
                    state_d = ST_CLOCK;
                end
            end
            ST_SETUP: begin
                presc_d = {PW{1'b0}};
                if (blink_cnt_q == BL_TC) begin
                    blink_cnt_d = {BW{1'b0}};
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BL_ONE;
                end
                // Mode press wins over any coincident position/increment press
                if (press_q[0]) begin
                    state_d = ST_CLOCK;
                end else begin
                    if (press_q[2]) begin
                        case (pos_q)
                            POS_SEC:  sec_d  = 1'b1;
                            POS_MIN:  min_d  = 1'b1;
                            POS_HOUR: hour_d = 1'b1;
                            default:  sec_d  = 1'b0;
                        endcase
                    end else begin
                        sec_d = 1'b0;
                    end
                    if (press_q[1]) begin
                        pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
                    end else begin
                        pos_d = pos_q;
                    end
                end
            end
            default: begin
                state_d = ST_CLOCK;
            end
        endcase
        if (state_d == ST_SETUP) begin
            mask_d = pos_onehot(pos_d) & {3{phase_d}};
        end else begin
            mask_d = 3'b000;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLOCK;
            pos_q       <= POS_SEC;
            presc_q     <= {PW{1'b0}};
            blink_cnt_q <= {BW{1'b0}};
            phase_q     <= 1'b0;
            sec_q       <= 1'b0;
            min_q       <= 1'b0;
            hour_q      <= 1'b0;
            mask_q      <= 3'b000;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            mask_q      <= mask_d;
        end
    end

    assign o_mode       = (state_q == ST_SETUP);
    assign o_position   = pos_q;
    assign o_sec_inc    = sec_q;
    assign o_min_inc    = min_q;
    assign o_hour_inc   = hour_q;
    assign o_blink_mask = mask_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: increment pulses go through a cycle-stamped scoreboard,
// mode/position/blink state is compared against a table of checkpoints.
module tb_clock_mode_ctrl;
    logic       clk;
    logic       rst_n;
    logic       sw0, sw1, sw2, sec_w, min_w;
    logic       o_mode;
    logic [1:0] o_position;
    logic       o_sec_inc, o_min_inc, o_hour_inc;
    logic [2:0] o_blink_mask;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic mon_en = 1'b0;
    logic [2:0] got_inc;

    clock_mode_ctrl #(.CLK_HZ(20), .DEB_CYC(4), .BLINK_DIV(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_sw0(sw0), .i_sw1(sw1), .i_sw2(sw2),
        .i_sec_wrap(sec_w), .i_min_wrap(min_w),
        .o_mode(o_mode), .o_position(o_position),
        .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc), .o_hour_inc(o_hour_inc),
        .o_blink_mask(o_blink_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle number = posedges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endfunction

    // scoreboard of expected {hour,min,sec} pulses, sorted by cycle
    typedef struct { int c; logic [2:0] inc; } sb_t;
    sb_t sb[$];

    function automatic void push_exp(input int c, input logic [2:0] v);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].c == c) begin
                sb[i].inc = sb[i].inc | v;
                return;
            end
            if (sb[i].c > c) begin
                sb.insert(i, '{c, v});
                return;
            end
        end
        sb.push_back('{c, v});
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            got_inc = {o_hour_inc, o_min_inc, o_sec_inc};
            if (sb.size() > 0 && sb[0].c == cyc) begin
                check("inc_pulse", int'(got_inc), int'(sb[0].inc));
                void'(sb.pop_front());
            end else if (got_inc != 3'b000) begin
                check("unexpected_inc", int'(got_inc), 0);
            end
        end
    end

    // status checkpoint table
    typedef struct { int at; logic mode; logic [1:0] pos; logic [2:0] mask; } st_t;
    localparam int NST = 22;
    st_t stat [NST];
    int st_idx = 0;

    always @(negedge clk) begin
        if (mon_en && st_idx < NST) begin
            if (stat[st_idx].at == cyc) begin
                check("mode", int'(o_mode), int'(stat[st_idx].mode));
                check("position", int'(o_position), int'(stat[st_idx].pos));
                check("blink_mask", int'(o_blink_mask), int'(stat[st_idx].mask));
                st_idx++;
            end
        end
    end

    // wrap-input vectors: {sec_wrap, min_wrap, expected {hour,min,sec} next cycle}
    typedef struct { logic sw; logic mw; logic [2:0] exp; } wv_t;
    wv_t wv [8];

    task automatic at_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) check("at_cyc", cyc, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        stat[0]  = '{1,   1'b0, 2'd0, 3'b000};
        stat[1]  = '{100, 1'b0, 2'd0, 3'b000};
        stat[2]  = '{116, 1'b0, 2'd0, 3'b000};
        stat[3]  = '{117, 1'b1, 2'd0, 3'b000};
        stat[4]  = '{186, 1'b1, 2'd0, 3'b001};
        stat[5]  = '{187, 1'b1, 2'd1, 3'b000};
        stat[6]  = '{192, 1'b1, 2'd1, 3'b010};
        stat[7]  = '{221, 1'b1, 2'd1, 3'b000};
        stat[8]  = '{222, 1'b0, 2'd1, 3'b000};
        stat[9]  = '{225, 1'b0, 2'd1, 3'b000};
        stat[10] = '{276, 1'b0, 2'd1, 3'b000};
        stat[11] = '{277, 1'b1, 2'd0, 3'b000};
        stat[12] = '{282, 1'b1, 2'd0, 3'b001};
        stat[13] = '{287, 1'b1, 2'd0, 3'b000};
        stat[14] = '{292, 1'b1, 2'd1, 3'b010};
        stat[15] = '{306, 1'b1, 2'd1, 3'b010};
        stat[16] = '{307, 1'b1, 2'd2, 3'b000};
        stat[17] = '{312, 1'b1, 2'd2, 3'b100};
        stat[18] = '{316, 1'b1, 2'd2, 3'b100};
        stat[19] = '{317, 1'b1, 2'd2, 3'b000};
        stat[20] = '{322, 1'b1, 2'd2, 3'b100};
        stat[21] = '{327, 1'b1, 2'd2, 3'b000};

        wv[0] = '{1'b1, 1'b0, 3'b010};
        wv[1] = '{1'b0, 1'b1, 3'b100};
        wv[2] = '{1'b1, 1'b1, 3'b110};
        wv[3] = '{1'b0, 1'b0, 3'b000};
        wv[4] = '{1'b1, 1'b0, 3'b010};
        wv[5] = '{1'b0, 1'b1, 3'b100};
        wv[6] = '{1'b0, 1'b0, 3'b000};
        wv[7] = '{1'b1, 1'b1, 3'b110};

        // seconds ticks in CLOCK mode, then button-driven increments in SETUP
        for (int k = 1; k <= 5; k++) push_exp(20 * k, 3'b001);
        for (int i = 0; i < 8; i++) begin
            if (wv[i].exp != 3'b000) push_exp(66 + 2 * i, wv[i].exp);
        end
        push_exp(142, 3'b001);
        push_exp(157, 3'b001);
        push_exp(172, 3'b001);
        push_exp(202, 3'b010);
        push_exp(242, 3'b001);
        push_exp(262, 3'b001);
        push_exp(307, 3'b010);

        rst_n = 1'b0;
        {sw0, sw1, sw2} = 3'b111;
        sec_w = 1'b0;
        min_w = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // carry inputs, one vector every other cycle; the last one lands on a seconds tick
        for (int i = 0; i < 8; i++) begin
            at_cyc(65 + 2 * i);
            sec_w = wv[i].sw;
            min_w = wv[i].mw;
            at_cyc(66 + 2 * i);
            sec_w = 1'b0;
            min_w = 1'b0;
        end

        at_cyc(90);  sw0 = 1'b0;
        at_cyc(93);  sw0 = 1'b1;
        at_cyc(110); sw0 = 1'b0;
        at_cyc(120); sw0 = 1'b1;

        at_cyc(135); sw2 = 1'b0;
        at_cyc(143); sw2 = 1'b1;
        at_cyc(150); sw2 = 1'b0;
        at_cyc(158); sw2 = 1'b1;
        at_cyc(165); sw2 = 1'b0;
        at_cyc(180); sw1 = 1'b0;
        at_cyc(185); sw2 = 1'b1;
        at_cyc(188); sw1 = 1'b1;
        at_cyc(195); sw2 = 1'b0;
        at_cyc(203); sw2 = 1'b1;
        at_cyc(205); sec_w = 1'b1;
        at_cyc(206); sec_w = 1'b0; min_w = 1'b1;
        at_cyc(207); min_w = 1'b0;

        at_cyc(215); sw0 = 1'b0; sw1 = 1'b0;
        at_cyc(225); sw0 = 1'b1; sw1 = 1'b1;

        at_cyc(270); sw0 = 1'b0;
        at_cyc(280); sw0 = 1'b1;
        at_cyc(285); sw1 = 1'b0;
        at_cyc(293); sw1 = 1'b1;
        at_cyc(300); sw1 = 1'b0; sw2 = 1'b0;
        at_cyc(308); sw1 = 1'b1; sw2 = 1'b1;

        // reset in the middle of an increment-button debounce while in SETUP/HOUR
        at_cyc(335); sw2 = 1'b0;
        at_cyc(338);
        check("sb_empty_before_reset", sb.size(), 0);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("rst_mode", int'(o_mode), 0);
        check("rst_position", int'(o_position), 0);
        check("rst_inc", int'({o_hour_inc, o_min_inc, o_sec_inc}), 0);
        check("rst_mask", int'(o_blink_mask), 0);
        sw2 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push_exp(20, 3'b001);
        push_exp(40, 3'b001);
        at_cyc(12);
        check("post_rst_mode", int'(o_mode), 0);
        at_cyc(45);
        check("sb_drained", sb.size(), 0);
        check("status_table_done", st_idx, NST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
